// File: rtl/icache_refill_ctrl.sv
// ICache refill controller: turns fetch-queue miss/uncached requests into one memory read burst each,
// streaming miss lines into the refill port or returning a single uncached word.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_BITS   = 7
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_miss,
    input  logic                                      req_uncached,
    input  logic [31:0]                               req_paddr,
    input  logic                                      abort,
    output logic                                      mem_arvalid,
    input  logic                                      mem_arready,
    output logic [31:0]                               mem_araddr,
    output logic [7:0]                                mem_arlen,
    input  logic                                      mem_rvalid,
    input  logic [31:0]                               mem_rdata,
    input  logic                                      mem_rlast,
    output logic                                      mem_rready,
    output logic                                      refill_we,
    output logic [IDX_BITS-1:0]                       refill_index,
    output logic [$clog2(LINE_WORDS)-1:0]             refill_word,
    output logic [31:0]                               refill_data,
    output logic                                      refill_tag_we,
    output logic [31-IDX_BITS-$clog2(LINE_WORDS)-2:0] refill_tag,
    output logic                                      refill_done,
    output logic                                      uncached_done,
    output logic [31:0]                               uncached_data,
    output logic                                      busy
);
    localparam int          WB        = $clog2(LINE_WORDS);
    localparam int          OFF       = WB + 2;
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [7:0]  MISS_LEN  = 8'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t        state_q,   state_d;
    logic          is_miss_q, is_miss_d;
    logic          abort_r_q, abort_r_d;
    logic [31:0]   addr_q,    addr_d;
    logic [7:0]    arlen_q,   arlen_d;
    logic [WB-1:0] beat_q,    beat_d;
    logic [31:0]   udata_q,   udata_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q,  rready_d;
    logic          busy_q,    busy_d;

    logic beat_ok, miss_beat, unc_beat, last_beat;

    // A beat that coincides with abort is treated as already squashed and is never written.
    always_comb begin
        beat_ok   = (state_q == S_DATA) && mem_rvalid && !abort;
        miss_beat = beat_ok && is_miss_q;
        unc_beat  = beat_ok && !is_miss_q;
        last_beat = mem_rvalid && mem_rlast;
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d   = state_q;
        is_miss_d = is_miss_q;
        abort_r_d = abort_r_q;
        addr_d    = addr_q;
        arlen_d   = arlen_q;
        beat_d    = beat_q;
        udata_d   = udata_q;
        unique case (state_q)
            S_IDLE: begin
                if ((req_miss || req_uncached) && !abort) begin
                    state_d   = S_ADDR;
                    is_miss_d = req_miss;
                    abort_r_d = 1'b0;
                    beat_d    = '0;
                    addr_d    = req_paddr & ~(req_miss ? LINE_MASK : 32'h3);
                    arlen_d   = req_miss ? MISS_LEN : 8'd0;
                end
            end
            S_ADDR: begin
                if (abort) abort_r_d = 1'b1;
                if (mem_arready) state_d = (abort_r_q || abort) ? S_DRAIN : S_DATA;
            end
            S_DATA: begin
                if (beat_ok)  beat_d  = beat_q + WB'(1);
                if (unc_beat) udata_d = mem_rdata;
                // An rlast that lands with abort still ends the burst; waiting in DRAIN would hang.
                if (last_beat)  state_d = S_RELEASE;
                else if (abort) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_beat) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!req_miss && !req_uncached) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        arvalid_d = (state_d == S_ADDR);
        rready_d  = (state_d == S_DATA) || (state_d == S_DRAIN);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            is_miss_q <= 1'b0;
            abort_r_q <= 1'b0;
            addr_q    <= '0;
            arlen_q   <= '0;
            beat_q    <= '0;
            udata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            state_q   <= state_d;
            is_miss_q <= is_miss_d;
            abort_r_q <= abort_r_d;
            addr_q    <= addr_d;
            arlen_q   <= arlen_d;
            beat_q    <= beat_d;
            udata_q   <= udata_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_arvalid   = arvalid_q;
    assign mem_araddr    = addr_q;
    assign mem_arlen     = arlen_q;
    assign mem_rready    = rready_q;
    assign refill_we     = miss_beat;
    assign refill_index  = addr_q[OFF +: IDX_BITS];
    assign refill_word   = beat_q;
    assign refill_data   = miss_beat ? mem_rdata : 32'h0;
    assign refill_tag_we = miss_beat && mem_rlast;
    assign refill_tag    = addr_q[31:OFF+IDX_BITS];
    assign refill_done   = miss_beat && mem_rlast;
    assign uncached_done = unc_beat && mem_rlast;
    assign uncached_data = unc_beat ? mem_rdata : udata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: memory side driven step by step, outputs checked by immediate asserts.
module tb_icache_refill_ctrl;
    logic        clk;
    logic        reset;
    logic        req_miss;
    logic        req_uncached;
    logic [31:0] req_paddr;
    logic        abort;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic        mem_rready;
    logic        refill_we;
    logic [6:0]  refill_index;
    logic [2:0]  refill_word;
    logic [31:0] refill_data;
    logic        refill_tag_we;
    logic [19:0] refill_tag;
    logic        refill_done;
    logic        uncached_done;
    logic [31:0] uncached_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    icache_refill_ctrl #(.LINE_WORDS(8), .IDX_BITS(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_miss     (req_miss),
        .req_uncached (req_uncached),
        .req_paddr    (req_paddr),
        .abort        (abort),
        .mem_arvalid  (mem_arvalid),
        .mem_arready  (mem_arready),
        .mem_araddr   (mem_araddr),
        .mem_arlen    (mem_arlen),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rlast    (mem_rlast),
        .mem_rready   (mem_rready),
        .refill_we    (refill_we),
        .refill_index (refill_index),
        .refill_word  (refill_word),
        .refill_data  (refill_data),
        .refill_tag_we(refill_tag_we),
        .refill_tag   (refill_tag),
        .refill_done  (refill_done),
        .uncached_done(uncached_done),
        .uncached_data(uncached_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later still.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_mem();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rlast   = 1'b0;
        mem_rdata   = 32'h0;
        abort       = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_arvalid"},  32'(mem_arvalid),   32'h0);
        check({nm, "_araddr"},   mem_araddr,         32'h0);
        check({nm, "_arlen"},    32'(mem_arlen),     32'h0);
        check({nm, "_rready"},   32'(mem_rready),    32'h0);
        check({nm, "_we"},       32'(refill_we),     32'h0);
        check({nm, "_index"},    32'(refill_index),  32'h0);
        check({nm, "_word"},     32'(refill_word),   32'h0);
        check({nm, "_data"},     refill_data,        32'h0);
        check({nm, "_tag_we"},   32'(refill_tag_we), 32'h0);
        check({nm, "_tag"},      32'(refill_tag),    32'h0);
        check({nm, "_done"},     32'(refill_done),   32'h0);
        check({nm, "_udone"},    32'(uncached_done), 32'h0);
        check({nm, "_udata"},    uncached_data,      32'h0);
        check({nm, "_busy"},     32'(busy),          32'h0);
    endtask

    // Full zero-wait miss; leaves the controller in RELEASE with req_miss still held.
    task automatic run_miss(input string nm, input logic [31:0] paddr, input logic [31:0] exp_addr,
                            input logic [31:0] exp_idx, input logic [31:0] exp_tag);
        req_miss  = 1'b1;
        req_paddr = paddr;
        #1;
        check({nm, "_idle_busy"}, 32'(busy), 32'h0);
        next_cycle();
        mem_arready = 1'b1;
        #1;
        check({nm, "_arvalid"}, 32'(mem_arvalid), 32'h1);
        check({nm, "_araddr"},  mem_araddr,       exp_addr);
        check({nm, "_arlen"},   32'(mem_arlen),   32'h7);
        check({nm, "_busy"},    32'(busy),        32'h1);
        next_cycle();
        mem_arready = 1'b0;
        #1;
        check({nm, "_arvalid_drop"}, 32'(mem_arvalid), 32'h0);
        check({nm, "_rready"},       32'(mem_rready),  32'h1);
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA0 + 32'(i);
            mem_rlast  = (i == 7);
            #1;
            check($sformatf("%s_we_%0d", nm, i),     32'(refill_we),     32'h1);
            check($sformatf("%s_word_%0d", nm, i),   32'(refill_word),   32'(i));
            check($sformatf("%s_data_%0d", nm, i),   refill_data,        32'hA0 + 32'(i));
            check($sformatf("%s_index_%0d", nm, i),  32'(refill_index),  exp_idx);
            check($sformatf("%s_tag_%0d", nm, i),    32'(refill_tag),    exp_tag);
            check($sformatf("%s_tag_we_%0d", nm, i), 32'(refill_tag_we), 32'(i == 7));
            check($sformatf("%s_done_%0d", nm, i),   32'(refill_done),   32'(i == 7));
            next_cycle();
        end
        idle_mem();
        #1;
        check({nm, "_tag_we_pulse"}, 32'(refill_tag_we), 32'h0);
        check({nm, "_done_pulse"},   32'(refill_done),   32'h0);
        check({nm, "_rready_end"},   32'(mem_rready),    32'h0);
        check({nm, "_release_busy"}, 32'(busy),          32'h1);
    endtask

    initial begin
        reset        = 1'b1;
        req_miss     = 1'b0;
        req_uncached = 1'b0;
        req_paddr    = 32'h0;
        idle_mem();
        next_cycle();
        next_cycle();
        check_zero("rst");
        reset = 1'b0;
        next_cycle();

        // Test 1: zero-wait miss of 0x8000_1234 (index 0x11, tag 0x80001).
        run_miss("t1", 32'h8000_1234, 32'h8000_1220, 32'h11, 32'h80001);

        // Test 5: held request must not start a second burst.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check($sformatf("t5_arvalid_%0d", i), 32'(mem_arvalid), 32'h0);
            check($sformatf("t5_busy_%0d", i),    32'(busy),        32'h1);
        end
        req_miss = 1'b0;
        next_cycle();
        check("t5_idle", 32'(busy), 32'h0);

        // Test 2: uncached word after three stall cycles.
        req_uncached = 1'b1;
        req_paddr    = 32'hBFC0_0006;
        next_cycle();
        mem_arready = 1'b1;
        #1;
        check("t2_arvalid", 32'(mem_arvalid), 32'h1);
        check("t2_araddr",  mem_araddr,       32'hBFC0_0004);
        check("t2_arlen",   32'(mem_arlen),   32'h0);
        next_cycle();
        mem_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t2_stall_rready_%0d", i), 32'(mem_rready),    32'h1);
            check($sformatf("t2_stall_udone_%0d", i),  32'(uncached_done), 32'h0);
            check($sformatf("t2_stall_we_%0d", i),     32'(refill_we),     32'h0);
            next_cycle();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        mem_rlast  = 1'b1;
        #1;
        check("t2_udone",  32'(uncached_done), 32'h1);
        check("t2_udata",  uncached_data,      32'hDEAD_BEEF);
        check("t2_we",     32'(refill_we),     32'h0);
        check("t2_done",   32'(refill_done),   32'h0);
        next_cycle();
        idle_mem();
        #1;
        check("t2_udone_pulse", 32'(uncached_done), 32'h0);
        check("t2_udata_hold",  uncached_data,      32'hDEAD_BEEF);
        check("t2_release",     32'(busy),          32'h1);
        req_uncached = 1'b0;
        next_cycle();
        check("t2_idle", 32'(busy), 32'h0);

        // Test 3: abort while arready is low; the burst is drained silently.
        req_miss  = 1'b1;
        req_paddr = 32'h0000_2040;
        next_cycle();
        abort = 1'b1;
        #1;
        check("t3_arvalid_abort", 32'(mem_arvalid), 32'h1);
        next_cycle();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_arvalid_hold_%0d", i), 32'(mem_arvalid), 32'h1);
            check($sformatf("t3_araddr_hold_%0d", i),  mem_araddr,       32'h0000_2040);
            next_cycle();
        end
        mem_arready = 1'b1;
        #1;
        check("t3_arvalid_hs", 32'(mem_arvalid), 32'h1);
        next_cycle();
        mem_arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hC0 + 32'(i);
            mem_rlast  = (i == 7);
            #1;
            check($sformatf("t3_rready_%0d", i), 32'(mem_rready),    32'h1);
            check($sformatf("t3_we_%0d", i),     32'(refill_we),     32'h0);
            check($sformatf("t3_tag_we_%0d", i), 32'(refill_tag_we), 32'h0);
            check($sformatf("t3_done_%0d", i),   32'(refill_done),   32'h0);
            next_cycle();
        end
        idle_mem();
        #1;
        check("t3_release", 32'(busy),       32'h1);
        check("t3_rready",  32'(mem_rready), 32'h0);
        req_miss = 1'b0;
        next_cycle();
        check("t3_idle", 32'(busy), 32'h0);

        // Test 4: abort coincides with beat 4, so only beats 0..3 are written.
        req_miss  = 1'b1;
        req_paddr = 32'h1234_5678;
        next_cycle();
        mem_arready = 1'b1;
        #1;
        check("t4_araddr", mem_araddr, 32'h1234_5660);
        next_cycle();
        mem_arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB0 + 32'(i);
            mem_rlast  = (i == 7);
            abort      = (i == 4);
            #1;
            check($sformatf("t4_we_%0d", i),     32'(refill_we),     32'(i < 4));
            check($sformatf("t4_tag_we_%0d", i), 32'(refill_tag_we), 32'h0);
            check($sformatf("t4_done_%0d", i),   32'(refill_done),   32'h0);
            if (i < 4) begin
                check($sformatf("t4_word_%0d", i),  32'(refill_word),  32'(i));
                check($sformatf("t4_index_%0d", i), 32'(refill_index), 32'h33);
                check($sformatf("t4_tag_%0d", i),   32'(refill_tag),   32'h12345);
            end else begin
                check($sformatf("t4_drain_rready_%0d", i), 32'(mem_rready), 32'h1);
            end
            next_cycle();
        end
        idle_mem();
        #1;
        check("t4_release",    32'(busy),     32'h1);
        check("t4_udata_hold", uncached_data, 32'hDEAD_BEEF);
        req_miss = 1'b0;
        next_cycle();
        check("t4_idle", 32'(busy), 32'h0);

        // Test 6: reset during beat 5 drops the burst; a fresh miss then completes normally.
        req_miss  = 1'b1;
        req_paddr = 32'h8000_1234;
        next_cycle();
        mem_arready = 1'b1;
        next_cycle();
        mem_arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hE0 + 32'(i);
            mem_rlast  = 1'b0;
            #1;
            check($sformatf("t6_we_%0d", i), 32'(refill_we), 32'h1);
            next_cycle();
        end
        mem_rdata = 32'hE5;
        reset     = 1'b1;
        req_miss  = 1'b0;
        next_cycle();
        idle_mem();
        #1;
        check_zero("t6_rst");
        reset = 1'b0;
        next_cycle();
        check_zero("t6_post");
        run_miss("t6m", 32'h8000_1234, 32'h8000_1220, 32'h11, 32'h80001);
        req_miss = 1'b0;
        next_cycle();
        check("t6_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
